// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory responder.
// Contents:
//   state_t         FSM states IDLE, CHECK, WRITE, FAULT
//   SZ_BYTE/HALF/WORD
//                   access-size codes carried in sign_mask[2:0]
//   is_misaligned   alignment rule for a size/byte-offset pair
//   lane_extract    picks a byte or halfword lane from a RAM word and extends it
//   lane_merge      inserts right-aligned store data into the lane of an old word
package dm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        WRITE,
        FAULT
    } state_t;

    localparam logic [2:0] SZ_BYTE = 3'b001;
    localparam logic [2:0] SZ_HALF = 3'b011;
    localparam logic [2:0] SZ_WORD = 3'b111;

    // Byte accesses can never be misaligned; any size code other than
    // half or word is handled as a byte.
    function automatic logic is_misaligned(input logic [2:0] size,
                                           input logic [1:0] off);
        is_misaligned = 1'b0;
        if (size == SZ_HALF)
            is_misaligned = off[0];
        else if (size == SZ_WORD)
            is_misaligned = (off != 2'b00);
    endfunction

    // Little-endian lane select followed by sign or zero extension.
    // Word accesses ignore zext.
    function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                 input logic [1:0]  off,
                                                 input logic [2:0]  size,
                                                 input logic        zext);
        logic [15:0] half_v;
        logic [7:0]  byte_v;
        half_v = off[1] ? word[31:16] : word[15:0];
        byte_v = 8'(word >> {off, 3'b000});
        case (size)
            SZ_WORD: lane_extract = word;
            SZ_HALF: lane_extract = zext ? {16'h0000, half_v} : {{16{half_v[15]}}, half_v};
            default: lane_extract = zext ? {24'h000000, byte_v} : {{24{byte_v[7]}}, byte_v};
        endcase
    endfunction

    // Read-modify-write merge: only the addressed lane of old_word changes.
    function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                               input logic [31:0] wdata,
                                               input logic [1:0]  off,
                                               input logic [2:0]  size);
        logic [31:0] byte_mask;
        byte_mask = 32'h0000_00FF << {off, 3'b000};
        case (size)
            SZ_WORD: lane_merge = wdata;
            SZ_HALF: lane_merge = off[1] ? {wdata[15:0], old_word[15:0]}
                                         : {old_word[31:16], wdata[15:0]};
            default: lane_merge = (old_word & ~byte_mask)
                                | ({24'h000000, wdata[7:0]} << {off, 3'b000});
        endcase
    endfunction

endpackage

// File: rtl/dm_sram.sv
// Single-port synchronous word RAM backing the data-memory responder.
// Ports:
//   clk    clock
//   we     write enable, writes wdata to mem[addr] on the rising edge
//   addr   word index
//   wdata  word to write
//   rdata  registered read of mem[addr], valid one cycle after addr
module dm_sram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Read-before-write behaviour: rdata returns the old word on a write cycle.
    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
        rdata <= mem[addr];
    end

endmodule

// File: rtl/data_mem_responder.sv
// Responder side of the core's data-memory interface. Loads return
// sign/zero-extended right-aligned data; byte and halfword stores are done
// as read-modify-write on a word RAM. clk_stall holds the pipeline while an
// access is in flight.
// Optional feature macro: DM_LED_REG_EN adds an 8-bit LED register at LED_ADDR.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   addr, write_data      byte address, right-aligned store data
//   memwrite, memread     store / load strobes (both set is a store)
//   sign_mask             [2:0] size code, [3] zero-extend loads
//   read_data             registered load result
//   clk_stall             combinational stall request
//   done                  one-cycle completion pulse
//   misaligned_err        pulses with done on a misaligned access
//   range_err             pulses with done on an out-of-range access
//   led                   LED register (only with DM_LED_REG_EN)
module data_mem_responder
    import dm_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter logic [31:0] LED_ADDR    = 32'h0000_2000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    input  logic        memwrite,
    input  logic        memread,
    input  logic [3:0]  sign_mask,
    output logic [31:0] read_data,
    output logic        clk_stall,
    output logic        done,
    output logic        misaligned_err,
    output logic        range_err
`ifdef DM_LED_REG_EN
    ,
    output logic [7:0]  led
`endif
);

    localparam int          AW       = $clog2(DEPTH_WORDS);
    localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;

    state_t      state;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_mask;
    logic        req_write;
    logic        req_led;
    logic        req_mis;
    logic        req_oor;
    logic [31:0] merge_word;
    logic [31:0] ram_rdata;
    logic [AW-1:0] ram_addr;
    logic        ram_we;
    logic [7:0]  led_value;

    logic        request;
    logic [31:0] in_offset;
    logic [31:0] req_offset;
    logic        in_window;
    logic        in_led;
    logic        in_mis;
    logic        in_oor;
    logic        unused_offset;

    assign request    = memread | memwrite;
    assign in_offset  = addr - BASE_ADDR;
    assign req_offset = req_addr - BASE_ADDR;
    assign in_window  = ({1'b0, addr} >= {1'b0, BASE_ADDR}) && ({1'b0, addr} < END_ADDR);
    assign in_mis     = is_misaligned(sign_mask[2:0], addr[1:0]);
    assign in_oor     = !in_window && !in_led;

`ifdef DM_LED_REG_EN
    assign in_led    = (addr == LED_ADDR);
    assign led_value = led;
`else
    logic unused_led_addr;
    assign in_led          = 1'b0;
    assign led_value       = 8'h00;
    assign unused_led_addr = ^LED_ADDR;
`endif

    assign unused_offset = ^{in_offset[31:AW+2], in_offset[1:0],
                             req_offset[31:AW+2], req_offset[1:0]};

    // The request-cycle address goes straight to the RAM so the word is
    // ready in CHECK; afterwards the captured address is used.
    assign ram_addr = (state == IDLE) ? in_offset[AW+1:2] : req_offset[AW+1:2];

    // Reset wins over the write strobe, so a store aborted in WRITE is lost.
    assign ram_we = (state == WRITE) && !reset && !req_led;

    // The done cycle is deliberately unstalled even if the request is still
    // held, letting the pipeline move on before a new access is accepted.
    assign clk_stall = (state != IDLE) || (request && !done);

    dm_sram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_sram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (merge_word),
        .rdata (ram_rdata)
    );

    // Access FSM with registered result and status pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            read_data      <= 32'h0;
            done           <= 1'b0;
            misaligned_err <= 1'b0;
            range_err      <= 1'b0;
            req_addr       <= 32'h0;
            req_wdata      <= 32'h0;
            req_mask       <= 4'h0;
            req_write      <= 1'b0;
            req_led        <= 1'b0;
            req_mis        <= 1'b0;
            req_oor        <= 1'b0;
            merge_word     <= 32'h0;
`ifdef DM_LED_REG_EN
            led            <= 8'h00;
`endif
        end else begin
            done           <= 1'b0;
            misaligned_err <= 1'b0;
            range_err      <= 1'b0;
            case (state)
                IDLE: begin
                    if (request && !done) begin
                        req_addr  <= addr;
                        req_wdata <= write_data;
                        req_mask  <= sign_mask;
                        req_write <= memwrite;
                        req_led   <= in_led;
                        req_mis   <= in_mis;
                        req_oor   <= in_oor;
                        state     <= (in_mis || in_oor) ? FAULT : CHECK;
                    end
                end
                CHECK: begin
                    if (req_write) begin
                        merge_word <= lane_merge(ram_rdata, req_wdata, req_addr[1:0], req_mask[2:0]);
                        state      <= WRITE;
                    end else begin
                        read_data <= req_led ? {24'h000000, led_value}
                                             : lane_extract(ram_rdata, req_addr[1:0],
                                                            req_mask[2:0], req_mask[3]);
                        done      <= 1'b1;
                        state     <= IDLE;
                    end
                end
                WRITE: begin
`ifdef DM_LED_REG_EN
                    if (req_led)
                        led <= req_wdata[7:0];
`endif
                    done  <= 1'b1;
                    state <= IDLE;
                end
                FAULT: begin
                    read_data      <= 32'h0;
                    misaligned_err <= req_mis;
                    range_err      <= req_oor;
                    done           <= 1'b1;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios followed by
// randomized accesses compared against a byte-addressed memory model.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic        memwrite;
    logic        memread;
    logic [3:0]  sign_mask;
    logic [31:0] read_data;
    logic        clk_stall;
    logic        done;
    logic        misaligned_err;
    logic        range_err;
`ifdef DM_LED_REG_EN
    logic [7:0]  led;
`endif

    data_mem_responder dut (
        .clk            (clk),
        .reset          (reset),
        .addr           (addr),
        .write_data     (write_data),
        .memwrite       (memwrite),
        .memread        (memread),
        .sign_mask      (sign_mask),
        .read_data      (read_data),
        .clk_stall      (clk_stall),
        .done           (done),
        .misaligned_err (misaligned_err),
        .range_err      (range_err)
`ifdef DM_LED_REG_EN
        ,
        .led            (led)
`endif
    );

    // 10 ns clock
    always #5 clk = ~clk;

    int          checkCount = 0;
    int          passCount  = 0;
    logic [31:0] resData;
    int          resLat;
    int          resStalls;
    logic        resMis;
    logic        resRng;
    logic        resDone;
    logic        resStallAtDone;

    // Reference memory: one entry per byte address.
    logic [7:0]  model [int];

    // One comparison; counts passes and reports failures.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    endtask

    // Drives one request at a falling edge and holds it until done or a
    // 20-cycle bound; records latency, stall count and the done-cycle outputs.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [3:0] mask);
        @(negedge clk);
        memread    = rd;
        memwrite   = wr;
        addr       = a;
        write_data = wd;
        sign_mask  = mask;
        resLat     = 0;
        resStalls  = 0;
        resDone    = 1'b0;
        while (!resDone && resLat < 20) begin
            #1;
            if (done) begin
                resDone        = 1'b1;
                resData        = read_data;
                resMis         = misaligned_err;
                resRng         = range_err;
                resStallAtDone = clk_stall;
            end else begin
                if (clk_stall) resStalls++;
                @(negedge clk);
                resLat++;
            end
        end
        if (!resDone) checkOutput("timeout", {31'b0, resDone}, 32'h1);
        memread  = 1'b0;
        memwrite = 1'b0;
    endtask

    function automatic int sizeBytes(input logic [2:0] size);
        if (size == 3'b111) return 4;
        if (size == 3'b011) return 2;
        return 1;
    endfunction

    task automatic modelStore(input logic [31:0] a, input logic [31:0] wd, input int n);
        for (int i = 0; i < n; i++) model[int'(a) + i] = wd[8*i +: 8];
    endtask

    function automatic logic [31:0] modelLoad(input logic [31:0] a, input int n, input logic zext);
        logic [31:0] v;
        v = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(model[int'(a) + i]) << (8 * i));
        if (n < 4 && !zext && v[8*n-1]) v = v | ~((32'h1 << (8 * n)) - 32'h1);
        return v;
    endfunction

    initial begin
        logic [31:0] a;
        logic [31:0] wd;
        logic [2:0]  size;
        logic        zext;
        logic        expMis;
        logic        expOor;
        int          n;
        int          op;

        reset      = 1'b1;
        memread    = 1'b0;
        memwrite   = 1'b0;
        addr       = 32'h0;
        write_data = 32'h0;
        sign_mask  = 4'h0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_read_data", read_data, 32'h0);
        checkOutput("rst_stall", {31'b0, clk_stall}, 32'h0);
        checkOutput("rst_done", {31'b0, done}, 32'h0);
        checkOutput("rst_errs", {30'b0, misaligned_err, range_err}, 32'h0);
`ifdef DM_LED_REG_EN
        checkOutput("rst_led", {24'b0, led}, 32'h0);
`endif
        reset = 1'b0;

        // Word store then word load
        applyStimulus(1'b0, 1'b1, 32'h1000, 32'hDEADBEEF, 4'b0111);
        checkOutput("st_word_lat", resLat, 3);
        applyStimulus(1'b1, 1'b0, 32'h1000, 32'h0, 4'b0111);
        checkOutput("ld_word_data", resData, 32'hDEADBEEF);
        checkOutput("ld_word_lat", resLat, 2);
        checkOutput("ld_word_stalls", resStalls, 2);
        checkOutput("ld_done_nostall", {31'b0, resStallAtDone}, 32'h0);

        // Byte merge and extension
        applyStimulus(1'b0, 1'b1, 32'h1004, 32'h11223344, 4'b0111);
        applyStimulus(1'b0, 1'b1, 32'h1006, 32'h000000F0, 4'b0001);
        checkOutput("st_byte_lat", resLat, 3);
        applyStimulus(1'b1, 1'b0, 32'h1004, 32'h0, 4'b0111);
        checkOutput("byte_merge", resData, 32'h11F03344);
        applyStimulus(1'b1, 1'b0, 32'h1006, 32'h0, 4'b0001);
        checkOutput("ld_byte_signed", resData, 32'hFFFFFFF0);
        applyStimulus(1'b1, 1'b0, 32'h1006, 32'h0, 4'b1001);
        checkOutput("ld_byte_unsigned", resData, 32'h000000F0);

        // Halfword lanes
        applyStimulus(1'b1, 1'b0, 32'h1006, 32'h0, 4'b0011);
        checkOutput("ld_half_hi", resData, 32'h000011F0);
        applyStimulus(1'b0, 1'b1, 32'h1004, 32'h00008001, 4'b0011);
        applyStimulus(1'b1, 1'b0, 32'h1004, 32'h0, 4'b0011);
        checkOutput("ld_half_signed", resData, 32'hFFFF8001);

        // Faults
        applyStimulus(1'b1, 1'b0, 32'h1002, 32'h0, 4'b0111);
        checkOutput("mis_flag", {30'b0, resMis, resRng}, 32'h2);
        checkOutput("mis_data", resData, 32'h0);
        checkOutput("mis_lat", resLat, 2);
        applyStimulus(1'b1, 1'b0, 32'h1000, 32'h0, 4'b0111);
        checkOutput("mis_ram_kept", resData, 32'hDEADBEEF);
        applyStimulus(1'b0, 1'b1, 32'h0FFC, 32'h12345678, 4'b0111);
        checkOutput("rng_flag", {30'b0, resMis, resRng}, 32'h1);
        checkOutput("rng_lat", resLat, 2);

        // LED register, or range error without the feature
        applyStimulus(1'b0, 1'b1, 32'h2000, 32'h000000A5, 4'b0111);
`ifdef DM_LED_REG_EN
        checkOutput("led_store_flags", {30'b0, resMis, resRng}, 32'h0);
        #1;
        checkOutput("led_value", {24'b0, led}, 32'hA5);
        applyStimulus(1'b1, 1'b0, 32'h2000, 32'h0, 4'b0111);
        checkOutput("led_load", resData, 32'h000000A5);
`else
        checkOutput("led_absent_rng", {30'b0, resMis, resRng}, 32'h1);
`endif

        // Reset during the WRITE cycle of a store
        applyStimulus(1'b0, 1'b1, 32'h1008, 32'h11111111, 4'b0111);
        @(negedge clk);
        memwrite   = 1'b1;
        addr       = 32'h1008;
        write_data = 32'hCAFEF00D;
        sign_mask  = 4'b0111;
        @(negedge clk);
        @(negedge clk);
        reset    = 1'b1;
        memwrite = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("rst_mid_done", {31'b0, done}, 32'h0);
        checkOutput("rst_mid_stall", {31'b0, clk_stall}, 32'h0);
        reset = 1'b0;
        applyStimulus(1'b1, 1'b0, 32'h1008, 32'h0, 4'b0111);
        checkOutput("rst_mid_kept", resData, 32'h11111111);

        // Randomized accesses against the byte model
        for (int i = 0; i < 16; i++) begin
            wd = $urandom;
            applyStimulus(1'b0, 1'b1, 32'h1100 + 32'(4 * i), wd, 4'b0111);
            modelStore(32'h1100 + 32'(4 * i), wd, 4);
        end
        for (int i = 0; i < 80; i++) begin
            op   = int'($urandom_range(0, 2));
            n    = int'($urandom_range(0, 2));
            size = (n == 0) ? 3'b001 : (n == 1) ? 3'b011 : 3'b111;
            n    = sizeBytes(size);
            zext = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) a = 32'h3000 + 32'($urandom_range(0, 15));
            else                           a = 32'h1100 + 32'($urandom_range(0, 63));
            wd     = $urandom;
            expMis = (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
            expOor = !(a >= 32'h1000 && a < 32'h2000);
            applyStimulus(op != 1, op != 0, a, wd, {zext, size});
            checkOutput("rnd_mis", {31'b0, resMis}, {31'b0, expMis});
            checkOutput("rnd_rng", {31'b0, resRng}, {31'b0, expOor});
            if (expMis || expOor) begin
                checkOutput("rnd_fault_lat", resLat, 2);
                checkOutput("rnd_fault_data", resData, 32'h0);
            end else if (op != 0) begin
                checkOutput("rnd_store_lat", resLat, 3);
                modelStore(a, wd, n);
            end else begin
                checkOutput("rnd_load_lat", resLat, 2);
                checkOutput("rnd_load_data", resData, modelLoad(a, n, zext));
            end
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
